// File: rtl/bitstream_eval_seq.sv
// Sequencer that pushes one operand pair through the stochastic generator/network
// datapath, counts ones on the network output over a 2^WINDOW_LOG2 window, and hands back the count.
module bitstream_eval_seq #(
  parameter int WIDTH       = 8,
  parameter int WINDOW_LOG2 = 8,
  parameter int WARMUP      = 2
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH:0]         in_x1,
  input  logic [WIDTH:0]         in_x2,
  output logic [WIDTH:0]         gen_x1,
  output logic [WIDTH:0]         gen_x2,
  output logic                   stream_en,
  input  logic                   net_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WINDOW_LOG2:0]   out_count,
  output logic [15:0]            points_done
);

  // One down-counter serves both the warm-up and the window phases, so it must hold either.
  localparam int CW = (WINDOW_LOG2 > 8) ? WINDOW_LOG2 : 8;
  localparam int AW = WINDOW_LOG2 + 1;
  localparam logic [CW-1:0] WARM_LOAD = CW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CW-1:0] WIN_LOAD  = CW'((1 << WINDOW_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_COUNT,
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   acc_next;

  assign in_ready = (state == S_IDLE);
  assign acc_next = acc + AW'(net_y);

  // NOTE: every register here, including the accumulator, is reset so an aborted window leaves
  // nothing behind; all state is assigned with <= so the whole block updates from pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      acc         <= '0;
      gen_x1      <= '0;
      gen_x2      <= '0;
      stream_en   <= 1'b0;
      out_valid   <= 1'b0;
      out_count   <= '0;
      points_done <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            gen_x1    <= in_x1;
            gen_x2    <= in_x2;
            acc       <= '0;
            stream_en <= 1'b1;
            if (WARMUP == 0) begin
              cnt   <= WIN_LOAD;
              state <= S_COUNT;
            end else begin
              cnt   <= WARM_LOAD;
              state <= S_WARMUP;
            end
          end
        end

        S_WARMUP: begin
          if (cnt == '0) begin
            cnt   <= WIN_LOAD;
            state <= S_COUNT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        S_COUNT: begin
          acc <= acc_next;
          // The last window edge folds its own sample into the reported count.
          if (cnt == '0) begin
            out_count <= acc_next;
            out_valid <= 1'b1;
            stream_en <= 1'b0;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            points_done <= points_done + 16'd1;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
